// File: rtl/mfp_pwm_multi_digit_display.sv
// Scanned multi-digit 7-segment driver: scan prescaler, brightness PWM,
// leading-zero blanking and a snapshot of the inputs taken once per frame.
module mfp_pwm_multi_digit_display #(
    parameter int N_DIGITS      = 8,
    parameter int SCAN_DIV_LOG2 = 17,
    parameter int PWM_BITS      = 4,
    parameter bit SEG_ACT_LOW   = 1'b1,
    parameter bit AN_ACT_LOW    = 1'b1
) (
    input  logic                    SI_ClkIn,
    input  logic                    SI_Reset,
    input  logic [4*N_DIGITS-1:0]   number,
    input  logic [N_DIGITS-1:0]     dots,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    lz_blank,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [6:0]              seven_segments,
    output logic                    dot,
    output logic [N_DIGITS-1:0]     anodes,
    output logic                    frame_tick
);
    localparam int                  IDX_W    = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_OFF  = {7{SEG_ACT_LOW}};
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACT_LOW}};

    logic [SCAN_DIV_LOG2-1:0] p;
    logic [IDX_W-1:0]         idx;
    logic                     first_cycle;  // first cycle after reset release
    logic                     wrapped;      // idx has just restarted at 0 after a full frame

    logic [4*N_DIGITS-1:0]    snap_number;
    logic [N_DIGITS-1:0]      snap_dots;
    logic [N_DIGITS-1:0]      snap_en;
    logic                     snap_lz;

    logic                     slot_end;
    logic                     wrap;
    logic                     lit_pwm;
    logic                     visible;
    logic [PWM_BITS-1:0]      ph;
    logic [N_DIGITS-1:0]      lz_blanked;
    logic [N_DIGITS-1:0]      sel;
    logic [3:0]               nibble;
    logic [6:0]               seg_raw;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        case (h)
            4'h0: hex_decode = 7'b0111111;
            4'h1: hex_decode = 7'b0000110;
            4'h2: hex_decode = 7'b1011011;
            4'h3: hex_decode = 7'b1001111;
            4'h4: hex_decode = 7'b1100110;
            4'h5: hex_decode = 7'b1101101;
            4'h6: hex_decode = 7'b1111101;
            4'h7: hex_decode = 7'b0000111;
            4'h8: hex_decode = 7'b1111111;
            4'h9: hex_decode = 7'b1101111;
            4'hA: hex_decode = 7'b1110111;
            4'hB: hex_decode = 7'b1111100;
            4'hC: hex_decode = 7'b0111001;
            4'hD: hex_decode = 7'b1011110;
            4'hE: hex_decode = 7'b1111001;
            default: hex_decode = 7'b1110001;
        endcase
    endfunction

    assign slot_end = &p;
    assign wrap     = slot_end && (idx == LAST_IDX);
    assign ph       = p[SCAN_DIV_LOG2-1 -: PWM_BITS];
    assign lit_pwm  = (&brightness) || (ph < brightness);
    assign nibble   = snap_number[{idx, 2'b00} +: 4];
    assign seg_raw  = hex_decode(nibble);
    assign visible  = snap_en[idx] && !lz_blanked[idx] && lit_pwm;

    // Scan from the most significant digit down; a disabled digit never stops the blanking.
    always_comb begin
        logic seen_nz;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        lz_blanked = '0;
        seen_nz    = 1'b0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            seen_nz       = seen_nz | (snap_en[k] && (snap_number[4*k +: 4] != 4'h0));
            lz_blanked[k] = snap_lz && !seen_nz && (k != 0);
        end
    end

    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            p              <= '0;
            idx            <= '0;
            first_cycle    <= 1'b1;
            wrapped        <= 1'b0;
            snap_number    <= '0;
            snap_dots      <= '0;
            snap_en        <= '0;
            snap_lz        <= 1'b0;
            seven_segments <= SEG_OFF;
            dot            <= SEG_ACT_LOW;
            anodes         <= AN_OFF;
            frame_tick     <= 1'b0;
        end else begin
            p           <= p + 1'b1;
            first_cycle <= 1'b0;
            wrapped     <= wrap;
            frame_tick  <= wrapped;
            if (slot_end) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            if (wrap || first_cycle) begin
                snap_number <= number;
                snap_dots   <= dots;
                snap_en     <= digit_en;
                snap_lz     <= lz_blank;
            end
            if (visible) begin
                seven_segments <= seg_raw ^ SEG_OFF;
                dot            <= snap_dots[idx] ^ SEG_ACT_LOW;
                anodes         <= sel ^ AN_OFF;
            end else begin
                seven_segments <= SEG_OFF;
                dot            <= SEG_ACT_LOW;
                anodes         <= AN_OFF;
            end
        end
    end

endmodule

// File: tb/tb_mfp_pwm_multi_digit_display.sv
// Randomized self-checking bench for mfp_pwm_multi_digit_display against a
// frame-level model driven by the number of cycles since reset release.
module tb_mfp_pwm_multi_digit_display;
    localparam int N    = 8;
    localparam int SDL  = 4;
    localparam int PB   = 2;
    localparam int SLOT = 1 << SDL;
    localparam int FRAME = SLOT * N;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*N-1:0] number;
    logic [N-1:0]  dots;
    logic [N-1:0]  digit_en;
    logic          lz_blank;
    logic [PB-1:0] brightness;
    logic [6:0]    seven_segments;
    logic          dot;
    logic [N-1:0]  anodes;
    logic          frame_tick;

    int errors = 0;
    int checks = 0;

    // Model state: cycles since reset release and the frame's captured inputs.
    int             rel;
    logic [4*N-1:0] m_num;
    logic [N-1:0]   m_dots;
    logic [N-1:0]   m_en;
    logic           m_lz;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    mfp_pwm_multi_digit_display #(
        .N_DIGITS(N), .SCAN_DIV_LOG2(SDL), .PWM_BITS(PB),
        .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
    ) dut (
        .SI_ClkIn(clk),
        .SI_Reset(rst),
        .number(number),
        .dots(dots),
        .digit_en(digit_en),
        .lz_blank(lz_blank),
        .brightness(brightness),
        .seven_segments(seven_segments),
        .dot(dot),
        .anodes(anodes),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (rel=%0d, t=%0t)", tag, got, exp, rel, $time);
        end
    endtask

    // One clock: predict outputs from the pre-edge model state, advance, compare.
    task automatic tick();
        logic [6:0]   e_seg;
        logic         e_dot;
        logic [N-1:0] e_an;
        logic         e_tick;
        if (rst) begin
            e_seg = 7'h7F; e_dot = 1'b1; e_an = '1; e_tick = 1'b0;
            rel = 0; m_num = '0; m_dots = '0; m_en = '0; m_lz = 1'b0;
        end else begin
            int digit, ph;
            logic [4*N-1:0] eff;
            logic lit, lead, vis;
            logic [3:0] nib;
            digit = (rel / SLOT) % N;
            ph    = (rel % SLOT) / (SLOT >> PB);
            lit   = (brightness == '1) || (ph < int'(brightness));
            eff   = '0;
            for (int d = 0; d < N; d++)
                if (m_en[d]) eff[4*d +: 4] = m_num[4*d +: 4];
            lead  = m_lz && (digit != 0) && ((eff >> (4 * digit)) == 0);
            vis   = m_en[digit] && !lead && lit;
            nib   = m_num[4*digit +: 4];
            e_seg = vis ? ~seg_tab[nib] : 7'h7F;
            e_dot = vis ? ~m_dots[digit] : 1'b1;
            e_an  = vis ? ~(N'(1) << digit) : '1;
            e_tick = (rel > 0) && (rel % FRAME == 0);
            if (rel == 0 || rel % FRAME == FRAME - 1) begin
                m_num = number; m_dots = dots; m_en = digit_en; m_lz = lz_blank;
            end
            rel++;
        end
        @(posedge clk);
        #1;
        check("anodes", 32'(anodes), 32'(e_an));
        check("segments", 32'(seven_segments), 32'(e_seg));
        check("dot", 32'(dot), 32'(e_dot));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; number = '0; dots = '0; digit_en = '0; lz_blank = 1'b0; brightness = '1;
        rel = 0; m_num = '0; m_dots = '0; m_en = '0; m_lz = 1'b0;
        run(3);
        rst = 1'b0;

        // Full brightness, all digits enabled.
        number = 32'h12345678; digit_en = '1; brightness = 2'd3;
        run(2 * FRAME + 40);

        // PWM duty levels (brightness is live).
        brightness = 2'd1; run(FRAME);
        brightness = 2'd0; run(FRAME / 2);
        brightness = 2'd2; run(FRAME / 2);
        brightness = 2'd3;

        // Leading-zero blanking.
        lz_blank = 1'b1; number = 32'h00000A05; run(2 * FRAME);
        number = 32'h0; run(2 * FRAME);

        // Input change during digit 3 must wait for the next frame.
        lz_blank = 1'b0; number = 32'h12345678;
        run(FRAME);
        while (((rel % FRAME) / SLOT) != 3) tick();
        run(5);
        number = 32'h9ABCDEF0;
        run(2 * FRAME);

        // Disabled digit 0 hides its dot.
        dots = 8'h01; digit_en = 8'hFE; run(2 * FRAME);
        dots = 8'hAA; digit_en = 8'hFF; lz_blank = 1'b1; number = 32'h00F00030; run(FRAME + 7);

        // One-cycle reset mid-slot.
        rst = 1'b1; tick(); rst = 1'b0;
        run(2 * FRAME + 5);

        // Randomized sweep, with occasional reset pulses.
        for (int it = 0; it < 30; it++) begin
            number     = $urandom;
            dots       = N'($urandom);
            digit_en   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            lz_blank   = 1'($urandom);
            brightness = PB'($urandom);
            if ($urandom_range(0, 3) == 0) number = number & 32'h0000_0FFF;
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            run($urandom_range(1, 200));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
